// File: rtl/aldff_load_scheduler.sv
// Round-robin scheduler that time-shares one async-load flip-flop bank between requesters.
// Each grant runs AD setup, L high for HOLD cycles, a GUARD window, then a one-cycle ack.
module aldff_load_scheduler #(
  parameter int NREQ  = 4,
  parameter int W     = 4,
  parameter int HOLD  = 2,
  parameter int GUARD = 1,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              C,
  input  logic              R,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_ad,
  input  logic              d_en,
  output logic [NREQ-1:0]   ack,
  output logic [ID_W-1:0]   grant_id,
  output logic              busy,
  output logic              ff_L,
  output logic [W-1:0]      ff_AD,
  output logic              ff_E
);

  localparam int CNT_W = $clog2(((HOLD > GUARD) ? HOLD : GUARD) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = (GUARD > 0) ? CNT_W'(GUARD - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GUARD, S_ACK} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [ID_W-1:0]   grant_nxt;
  logic [W-1:0]      ad_nxt;
  logic              busy_nxt, l_nxt;
  logic [NREQ-1:0]   ack_nxt;
  logic [ID_W:0]     pick;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;

  // First requester at or after p, wrapping; MSB flags that one was found.
  function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] r, input logic [ID_W-1:0] p);
    logic [ID_W:0] res;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int j;
      j = (int'(p) + i) % NREQ;
      if (r[j]) res = {1'b1, ID_W'(j)};
    end
    return res;
  endfunction

  assign pick      = rr_pick(req, ptr);
  assign win_found = pick[ID_W];
  assign win_idx   = pick[ID_W-1:0];

  // The bank may only capture D while no load is anywhere in flight.
  assign ff_E = d_en & R & (state == S_IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    grant_nxt = grant_id;
    ad_nxt    = ff_AD;
    busy_nxt  = busy;
    l_nxt     = ff_L;
    ack_nxt   = '0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          grant_nxt = win_idx;
          ad_nxt    = req_ad[int'(win_idx)*W +: W];
          busy_nxt  = 1'b1;
          l_nxt     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cnt == HOLD_LAST) begin
          l_nxt   = 1'b0;
          cnt_nxt = '0;
          if (GUARD == 0) begin
            state_nxt = S_ACK;
            ack_nxt   = NREQ'(1) << grant_id;
            busy_nxt  = 1'b0;
          end else begin
            state_nxt = S_GUARD;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_nxt = S_ACK;
          ack_nxt   = NREQ'(1) << grant_id;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_ACK: begin
        state_nxt = S_IDLE;
        ptr_nxt   = ID_W'((int'(grant_id) + 1) % NREQ);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      grant_id <= '0;
      ff_AD    <= '0;
      busy     <= 1'b0;
      ff_L     <= 1'b0;
      ack      <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_nxt;
      ff_AD    <= ad_nxt;
      busy     <= busy_nxt;
      ff_L     <= l_nxt;
      ack      <= ack_nxt;
    end
  end

endmodule

// File: tb/tb_aldff_load_scheduler.sv
// Bench for aldff_load_scheduler: phase-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_aldff_load_scheduler;
  localparam int NREQ = 4, W = 4, HOLD = 2, GUARD = 1;

  logic        C = 1'b0;
  logic        R;
  logic [3:0]  req;
  logic [15:0] req_ad;
  logic        d_en;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy, ff_L, ff_E;
  logic [3:0]  ff_AD;

  aldff_load_scheduler #(.NREQ(NREQ), .W(W), .HOLD(HOLD), .GUARD(GUARD)) dut (
    .C(C), .R(R), .req(req), .req_ad(req_ad), .d_en(d_en),
    .ack(ack), .grant_id(grant_id), .busy(busy), .ff_L(ff_L), .ff_AD(ff_AD), .ff_E(ff_E)
  );

  always #5 C = ~C;

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge C) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: a grant starts a sequence whose outputs are fixed by the number of edges since it.
  bit       m_act;
  int       m_k, m_g, m_ptr;
  bit [3:0] m_ad;
  always @(posedge C or negedge R) begin
    if (!R) begin
      m_act = 0; m_k = 0; m_g = 0; m_ptr = 0; m_ad = 0;
    end else if (!m_act) begin
      for (int i = 0; i < NREQ; i++) begin
        int j;
        j = (m_ptr + i) % NREQ;
        if (!m_act && req[j]) begin
          m_act = 1; m_k = 0; m_g = j; m_ad = req_ad[j*W +: W];
        end
      end
    end else begin
      m_k++;
      if (m_k == HOLD + GUARD + 1) begin
        m_act = 0;
        m_ptr = (m_g + 1) % NREQ;
      end
    end
  end

  always @(negedge C) begin
    logic       e_L, e_busy, e_E;
    logic [3:0] e_ack, e_ad;
    e_L = 0; e_busy = 0; e_ack = 0; e_E = 0; e_ad = 0;
    if (R) begin
      e_ad = m_ad;
      if (m_act) begin
        e_L    = (m_k < HOLD);
        e_busy = (m_k < HOLD + GUARD);
        e_ack  = (m_k == HOLD + GUARD) ? (4'b0001 << m_g) : 4'b0000;
      end else begin
        e_E = d_en;
      end
    end
    chk("mdl_ff_L", ff_L, e_L);
    chk("mdl_busy", busy, e_busy);
    chk("mdl_ack", ack, e_ack);
    chk("mdl_ff_E", ff_E, e_E);
    chk("mdl_ff_AD", ff_AD, e_ad);
    if (e_busy) chk("mdl_grant_id", grant_id, m_g);
  end

  int ack_idx[$];
  int ack_cyc[$];
  always @(negedge C) begin
    if (R && ack != 0)
      for (int i = 0; i < NREQ; i++)
        if (ack[i]) begin
          ack_idx.push_back(i);
          ack_cyc.push_back(cyc);
        end
  end

  task automatic step();
    @(posedge C);
    #2;
  endtask

  task automatic set_ad(int i, logic [3:0] v);
    req_ad[i*W +: W] = v;
  endtask

  task automatic pulse_reset();
    R = 1'b0;
    step();
    R = 1'b1;
    step();
  endtask

  task automatic wait_ack(int i, int maxc);
    bit got;
    got = 0;
    for (int c = 0; c < maxc && !got; c++) begin
      step();
      if (ack[i]) got = 1;
    end
    chk($sformatf("ack%0d_wait", i), got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp3[4];
    int exp4[3];
    int n_before;
    exp3 = '{0, 1, 3, 0};
    exp4 = '{0, 2, 0};

    // Reset with everything requesting
    R = 1'b0; req = 4'hF; d_en = 1'b1; req_ad = 16'h4321;
    repeat (3) step();
    chk("rst_ff_L", ff_L, 0);
    chk("rst_ff_E", ff_E, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ff_AD", ff_AD, 0);
    req = 4'h0; R = 1'b1;
    step(); step();

    // Single requester 2
    set_ad(2, 4'hA); req = 4'b0100;
    step();
    chk("t2_ad", ff_AD, 4'hA);
    chk("t2_L_t1", ff_L, 1);
    chk("t2_E_t1", ff_E, 0);
    chk("t2_gid", grant_id, 2);
    step();
    chk("t2_L_t2", ff_L, 1);
    chk("t2_E_t2", ff_E, 0);
    step();
    chk("t2_L_t3", ff_L, 0);
    chk("t2_busy_t3", busy, 1);
    chk("t2_E_t3", ff_E, 0);
    step();
    chk("t2_ack_t4", ack, 4'b0100);
    chk("t2_busy_t4", busy, 0);
    chk("t2_E_t4", ff_E, 0);
    req = 4'b0000;
    step();
    chk("t2_ack_t5", ack, 0);
    chk("t2_E_t5", ff_E, 1);
    chk("t2_ad_held", ff_AD, 4'hA);
    d_en = 1'b0; #1;
    chk("t2_E_follow", ff_E, 0);
    d_en = 1'b1;
    step();

    // Contention, ptr from 0
    pulse_reset();
    ack_idx.delete(); ack_cyc.delete();
    req = 4'b1011;
    for (int c = 0; c < 60 && ack_idx.size() < 4; c++) step();
    req = 4'b0000;
    chk("t3_count", ack_idx.size() >= 4, 1);
    if (ack_idx.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t3_order%0d", i), ack_idx[i], exp3[i]);
      for (int i = 1; i < 4; i++) chk($sformatf("t3_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 5);
    end
    repeat (3) step();

    // Fairness: requester 0 never lets go, requester 2 joins
    pulse_reset();
    ack_idx.delete(); ack_cyc.delete();
    req = 4'b0001;
    step();
    req = 4'b0101;
    for (int c = 0; c < 60 && ack_idx.size() < 3; c++) begin
      step();
      if (ack[2]) req[2] = 1'b0;
    end
    req = 4'b0000;
    chk("t4_count", ack_idx.size() >= 3, 1);
    if (ack_idx.size() >= 3)
      for (int i = 0; i < 3; i++) chk($sformatf("t4_order%0d", i), ack_idx[i], exp4[i]);
    repeat (3) step();

    // Abort in the second LOAD cycle
    req = 4'b0100;
    step();
    step();
    chk("t5_L_before", ff_L, 1);
    n_before = ack_idx.size();
    R = 1'b0; #1;
    chk("t5_L_abort", ff_L, 0);
    chk("t5_busy_abort", busy, 0);
    chk("t5_ack_abort", ack, 0);
    req = 4'b0000;
    step(); step();
    chk("t5_no_ack", ack_idx.size(), n_before);
    R = 1'b1;
    step();
    req = 4'b1001;
    step();
    chk("t5_gid_ptr0", grant_id, 0);
    chk("t5_L_restart", ff_L, 1);
    wait_ack(0, 10);
    req = 4'b1000;
    wait_ack(3, 12);
    req = 4'b0000;
    repeat (2) step();

    // Data stability and dropped request
    set_ad(1, 4'h5); req = 4'b0010;
    step();
    chk("t6_ad_grant", ff_AD, 4'h5);
    chk("t6_gid", grant_id, 1);
    set_ad(1, 4'hC); req = 4'b0000;
    step();
    chk("t6_ad_load2", ff_AD, 4'h5);
    step();
    chk("t6_ad_guard", ff_AD, 4'h5);
    wait_ack(1, 6);
    chk("t6_ad_ack", ff_AD, 4'h5);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
